// File: rtl/int_sched.sv
// int_sched: programmable interrupt scheduler between peripheral IRQ lines and CP0.
//
// Synchronises NSRC raw interrupt lines, latches them per-source as edge- or
// level-triggered pending bits, masks them and picks the lowest-index eligible
// source as the single in-service interrupt. After a software ACK the scheduler
// sits out HOLDOFF_CYC cycles before it will schedule another source.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   DEV_Addr  bridge word address [7:2]; only DEV_Addr[1:0] is decoded
//             0 MASK (RW), 1 PEND (R, W1C for edge sources), 2 MODE (RW, 1=edge),
//             3 VEC  (R {busy,28'b0,insvc}, any write = ACK)
//   DEV_We    write strobe
//   DEV_Wd    write data
//   DEV_Rd    read data, combinational from DEV_Addr
//   IrqIn     raw interrupt lines, asynchronous to clk
//   HWInt     one-hot in-service interrupt, registered-state decode

module int_sched #(
    parameter int NSRC        = 6,
    parameter int HOLDOFF_CYC = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      DEV_Addr,
    input  logic            DEV_We,
    input  logic [31:0]     DEV_Wd,
    output logic [31:0]     DEV_Rd,
    input  logic [NSRC-1:0] IrqIn,
    output logic [NSRC-1:0] HWInt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    logic [NSRC-1:0] s1_q, s2_q, p_q;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mode_q;
    state_t          state_q, state_d;
    logic [2:0]      insvc_q, insvc_d;
    logic [7:0]      hcnt_q, hcnt_d;

    logic [1:0]      sel;
    logic            wr_mask, wr_pend, wr_mode, wr_vec;
    logic            ack;
    logic [NSRC-1:0] eligible, clr, rise;
    logic [2:0]      pick;
    logic            unused_bits;

    assign sel      = DEV_Addr[1:0];
    assign wr_mask  = DEV_We && (sel == 2'd0);
    assign wr_pend  = DEV_We && (sel == 2'd1);
    assign wr_mode  = DEV_We && (sel == 2'd2);
    assign wr_vec   = DEV_We && (sel == 2'd3);
    assign ack      = wr_vec && (state_q == ACTIVE);
    assign eligible = pend_q & mask_q;
    assign rise     = s2_q & ~p_q;

    assign unused_bits = ^{DEV_Addr[5:2], DEV_Wd[31:NSRC]};

    // Edge sources: W1C and ACK clear, a fresh rising edge wins over both.
    // Level sources simply track the synchronised line.
    always_comb begin
        clr = '0;
        if (wr_pend) clr = DEV_Wd[NSRC-1:0];
        if (ack)     clr[insvc_q] = 1'b1;
        pend_d = (mode_q & ((pend_q & ~clr) | rise)) | (~mode_q & s2_q);
    end

    // Fixed priority: lowest index wins, so scan downward and let it overwrite.
    always_comb begin
        pick = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) pick = 3'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        insvc_d = insvc_q;
        hcnt_d  = hcnt_q;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    insvc_d = pick;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (ack) begin
                    hcnt_d  = 8'(HOLDOFF_CYC - 1);
                    state_d = HOLDOFF;
                end else if (!mask_q[insvc_q] ||
                             (!mode_q[insvc_q] && !pend_q[insvc_q])) begin
                    // Source withdrawn without an ACK: give up, pending untouched.
                    state_d = IDLE;
                end
            end
            HOLDOFF: begin
                if (hcnt_q == 8'd0) state_d = IDLE;
                else                hcnt_d  = hcnt_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            p_q     <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            mode_q  <= '0;
            state_q <= IDLE;
            insvc_q <= '0;
            hcnt_q  <= '0;
        end else begin
            s1_q    <= IrqIn;
            s2_q    <= s1_q;
            p_q     <= s2_q;
            pend_q  <= pend_d;
            if (wr_mask) mask_q <= DEV_Wd[NSRC-1:0];
            if (wr_mode) mode_q <= DEV_Wd[NSRC-1:0];
            state_q <= state_d;
            insvc_q <= insvc_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign HWInt = (state_q == ACTIVE) ? (NSRC'(1) << insvc_q) : '0;

    always_comb begin
        DEV_Rd = '0;
        case (sel)
            2'd0: DEV_Rd[NSRC-1:0] = mask_q;
            2'd1: DEV_Rd[NSRC-1:0] = pend_q;
            2'd2: DEV_Rd[NSRC-1:0] = mode_q;
            default: begin
                DEV_Rd[31]  = (state_q != IDLE);
                DEV_Rd[2:0] = insvc_q;
            end
        endcase
    end

endmodule

// File: tb/tb_int_sched.sv
// Bench for int_sched: directed stimulus with literal expectations, plus a
// cycle-level reference model checked against HWInt/DEV_Rd on every negedge.

module tb_int_sched;

    localparam int HOLD = 4;

    logic        clk;
    logic        rst = 1'b1;
    logic [5:0]  DEV_Addr = '0;
    logic        DEV_We = 1'b0;
    logic [31:0] DEV_Wd = '0;
    logic [31:0] DEV_Rd;
    logic [5:0]  IrqIn = '0;
    logic [5:0]  HWInt;

    int nvec = 0;
    int nerr = 0;

    int_sched #(.NSRC(6), .HOLDOFF_CYC(HOLD)) dut (
        .clk(clk), .rst(rst),
        .DEV_Addr(DEV_Addr), .DEV_We(DEV_We), .DEV_Wd(DEV_Wd), .DEV_Rd(DEV_Rd),
        .IrqIn(IrqIn), .HWInt(HWInt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: line history, pending set, and a scheduler described by
    // "which source is served" (-1 = none) and "cycles of hold-off left".
    logic [5:0] h1, h2, h3, m_pend, m_mask, m_mode;
    logic [5:0] rise, clr, nxt_pend;
    logic       m_ack;
    int         svc, hold, last;

    function automatic int lowest(input logic [5:0] v);
        int r = -1;
        for (int i = 0; i < 6; i++) if (v[i] && r < 0) r = i;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            h1 = 0; h2 = 0; h3 = 0;
            m_pend = 0; m_mask = 0; m_mode = 0;
            svc = -1; hold = 0; last = 0;
        end else begin
            rise  = h2 & ~h3;
            m_ack = DEV_We && DEV_Addr[1:0] == 2'd3 && svc >= 0;
            clr   = (DEV_We && DEV_Addr[1:0] == 2'd1) ? DEV_Wd[5:0] : 6'd0;
            if (m_ack) clr = clr | (6'd1 << svc);
            nxt_pend = (m_mode & ((m_pend & ~clr) | rise)) | (~m_mode & h2);
            if (hold > 0) begin
                hold = hold - 1;
            end else if (svc < 0) begin
                if ((m_pend & m_mask) != 0) begin
                    svc  = lowest(m_pend & m_mask);
                    last = svc;
                end
            end else if (m_ack) begin
                svc  = -1;
                hold = HOLD;
            end else if (!m_mask[svc] || (!m_mode[svc] && !m_pend[svc])) begin
                svc = -1;
            end
            if (DEV_We && DEV_Addr[1:0] == 2'd0) m_mask = DEV_Wd[5:0];
            if (DEV_We && DEV_Addr[1:0] == 2'd2) m_mode = DEV_Wd[5:0];
            m_pend = nxt_pend;
            h3 = h2; h2 = h1; h1 = IrqIn;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0: return {26'd0, m_mask};
            2'd1: return {26'd0, m_pend};
            2'd2: return {26'd0, m_mode};
            default: return {(svc >= 0 || hold > 0), 28'd0, 3'(last)};
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            logic [5:0] ehw;
            ehw = (svc >= 0) ? (6'd1 << svc) : 6'd0;
            nvec++;
            if (HWInt !== ehw) begin
                nerr++;
                $display("FAIL model_hwint t=%0t got %h want %h", $time, HWInt, ehw);
            end
            nvec++;
            if (DEV_Rd !== exp_rd(DEV_Addr[1:0])) begin
                nerr++;
                $display("FAIL model_rd a=%0d t=%0t got %h want %h",
                         DEV_Addr[1:0], $time, DEV_Rd, exp_rd(DEV_Addr[1:0]));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        DEV_Addr = a; DEV_Wd = d; DEV_We = 1'b1;
        tick(1);
        DEV_We = 1'b0;
    endtask

    task automatic rdchk(input string name, input logic [5:0] a, input logic [31:0] exp);
        DEV_Addr = a;
        #1;
        chk(name, DEV_Rd, exp);
    endtask

    task automatic pulse(input logic [5:0] v);
        IrqIn = v;
        tick(1);
        IrqIn = '0;
    endtask

    initial begin
        tick(2);
        chk("reset_hwint", {26'd0, HWInt}, 32'd0);
        rdchk("reset_vec", 6'd3, 32'd0);
        rst = 1'b0;
        tick(1);

        // Single edge source, latency and VEC/PEND readback
        wr(6'd0, 32'h3F);
        wr(6'd2, 32'h3F);
        pulse(6'h04);
        tick(2);
        chk("lat_before_e3", {26'd0, HWInt}, 32'd0);
        tick(1);
        chk("lat_e3_hwint", {26'd0, HWInt}, 32'h04);
        rdchk("t1_vec", 6'd3, 32'h8000_0002);
        rdchk("t1_pend", 6'd1, 32'h04);
        wr(6'd3, 32'h0);
        tick(6);

        // Two edge sources: priority, ACK, hold-off
        pulse(6'h12);
        tick(3);
        chk("prio_hwint", {26'd0, HWInt}, 32'h02);
        wr(6'd3, 32'h0);
        chk("holdoff_0", {26'd0, HWInt}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            chk($sformatf("holdoff_%0d", k), {26'd0, HWInt}, 32'd0);
        end
        tick(1);
        chk("next_hwint", {26'd0, HWInt}, 32'h10);
        rdchk("t2_pend", 6'd1, 32'h10);
        wr(6'd3, 32'h0);
        tick(6);

        // Level source 3
        wr(6'd2, 32'h37);
        IrqIn = 6'h08;
        tick(4);
        chk("lvl_hwint", {26'd0, HWInt}, 32'h08);
        wr(6'd3, 32'h0);
        tick(5);
        chk("lvl_reassert", {26'd0, HWInt}, 32'h08);
        rdchk("lvl_pend", 6'd1, 32'h08);
        IrqIn = '0;
        tick(3);
        chk("lvl_drop_late", {26'd0, HWInt}, 32'h08);
        tick(1);
        chk("lvl_drop_hwint", {26'd0, HWInt}, 32'd0);
        rdchk("lvl_drop_vec", 6'd3, 32'h0000_0003);

        // Masking the in-service edge source
        pulse(6'h20);
        tick(3);
        chk("m5_hwint", {26'd0, HWInt}, 32'h20);
        wr(6'd0, 32'h1F);
        chk("m5_still", {26'd0, HWInt}, 32'h20);
        tick(1);
        chk("m5_masked", {26'd0, HWInt}, 32'd0);
        rdchk("m5_pend", 6'd1, 32'h20);
        wr(6'd0, 32'h3F);
        tick(1);
        chk("m5_unmask", {26'd0, HWInt}, 32'h20);
        wr(6'd3, 32'h0);
        tick(6);

        // Set/clear collision, plain W1C, ACK in IDLE
        wr(6'd0, 32'h3E);
        pulse(6'h01);
        tick(1);
        wr(6'd1, 32'h01);
        rdchk("collide_pend", 6'd1, 32'h01);
        wr(6'd1, 32'h01);
        rdchk("w1c_pend", 6'd1, 32'h00);
        pulse(6'h01);
        tick(3);
        rdchk("repend", 6'd1, 32'h01);
        wr(6'd3, 32'h0);
        rdchk("idle_ack_pend", 6'd1, 32'h01);
        rdchk("idle_ack_vec", 6'd3, 32'h0000_0005);

        // Asynchronous reset while source 0 is in service
        wr(6'd0, 32'h3F);
        tick(1);
        chk("pre_rst_hwint", {26'd0, HWInt}, 32'h01);
        #1 rst = 1'b1;
        #1 chk("rst_hwint", {26'd0, HWInt}, 32'd0);
        rdchk("rst_mask", 6'd0, 32'd0);
        tick(1);
        rdchk("rst_mode", 6'd2, 32'd0);
        rdchk("rst_pend", 6'd1, 32'd0);
        rst = 1'b0;
        IrqIn = 6'h3F;
        tick(6);
        chk("post_rst_nomask", {26'd0, HWInt}, 32'd0);
        rdchk("post_rst_pend", 6'd1, 32'h3F);
        wr(6'd0, 32'h3F);
        tick(1);
        chk("post_rst_hwint", {26'd0, HWInt}, 32'h01);
        IrqIn = '0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
